vram_access_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-read-latency VRAM (32-bit words, 4 glyph bytes each)

---
 rtl/vram_access_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_vram_access_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// Arbitrates one single-port VRAM between the Avalon CPU slave and the VGA glyph fetcher.
// Optional CPU anti-starvation limit on VGA bursts: define VRAM_ARB_FAIRNESS_EN.
module vram_access_arbiter #(
  parameter int DEPTH         = 600,
  parameter int ADDR_W        = 10,
  parameter int MAX_VGA_BURST = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic              AVL_CS,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic              AVL_WAITREQUEST,
  input  logic              VGA_REQ,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  output logic [31:0]       VGA_RDATA,
  output logic              VGA_VALID,
  output logic              VGA_OVERRUN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [3:0]        RAM_BE,
  output logic [31:0]       RAM_WDATA,
  input  logic [31:0]       RAM_RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VGA_ISSUE,
    S_VGA_DATA,
    S_CPU_ISSUE,
    S_CPU_DATA
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  state_t            state_q, state_d;
  logic              vga_pend_q, vga_pend_d;
  logic [ADDR_W-1:0] vga_pend_addr_q, vga_pend_addr_d;
  logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
  logic              vga_inr_q, vga_inr_d;
  logic [31:0]       vga_rdata_q, vga_rdata_d;
  logic              vga_ovr_q, vga_ovr_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [31:0]       cpu_wdata_q, cpu_wdata_d;
  logic [3:0]        cpu_be_q, cpu_be_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              cpu_inr_q, cpu_inr_d;

  logic              cpu_req;
  logic              vga_want;
  logic              cpu_turn;
  logic              vga_grant;
  logic              cpu_grant;
  logic [ADDR_W-1:0] vga_sel_addr;

  // A fetch pulse arriving in IDLE is granted directly so VGA data lands two cycles later.
  assign cpu_req      = AVL_CS & (AVL_READ | AVL_WRITE);
  assign vga_want     = vga_pend_q | VGA_REQ;
  assign vga_sel_addr = VGA_REQ ? VGA_ADDR : vga_pend_addr_q;
  assign vga_grant    = (state_q == S_IDLE) && vga_want && !cpu_turn;
  assign cpu_grant    = (state_q == S_IDLE) && cpu_req && !vga_grant;

`ifdef VRAM_ARB_FAIRNESS_EN
  localparam int CNT_W = (MAX_VGA_BURST < 1) ? 1 : $clog2(MAX_VGA_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_VGA_BURST);

  logic [CNT_W-1:0] burst_q, burst_d;

  assign cpu_turn = cpu_req && (burst_q >= BURST_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

  // Counts VGA grants taken while the CPU is left waiting; any CPU grant clears it.
  always_comb begin
    burst_d = burst_q;
    if (cpu_grant) begin
      burst_d = '0;
    end else if (vga_grant && cpu_req) begin
      burst_d = burst_q + 1'b1;
    end
  end
`else
  // Strict VGA priority: the burst limit is inert in this build.
  assign cpu_turn = (MAX_VGA_BURST < 0);
`endif

  assign VGA_OVERRUN = vga_ovr_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      vga_pend_q      <= 1'b0;
      vga_pend_addr_q <= '0;
      vga_addr_q      <= '0;
      vga_inr_q       <= 1'b0;
      vga_rdata_q     <= '0;
      vga_ovr_q       <= 1'b0;
      cpu_addr_q      <= '0;
      cpu_wdata_q     <= '0;
      cpu_be_q        <= '0;
      cpu_rd_q        <= 1'b0;
      cpu_inr_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      vga_pend_q      <= vga_pend_d;
      vga_pend_addr_q <= vga_pend_addr_d;
      vga_addr_q      <= vga_addr_d;
      vga_inr_q       <= vga_inr_d;
      vga_rdata_q     <= vga_rdata_d;
      vga_ovr_q       <= vga_ovr_d;
      cpu_addr_q      <= cpu_addr_d;
      cpu_wdata_q     <= cpu_wdata_d;
      cpu_be_q        <= cpu_be_d;
      cpu_rd_q        <= cpu_rd_d;
      cpu_inr_q       <= cpu_inr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    vga_pend_d      = vga_pend_q;
    vga_pend_addr_d = vga_pend_addr_q;
    vga_addr_d      = vga_addr_q;
    vga_inr_d       = vga_inr_q;
    vga_rdata_d     = vga_rdata_q;
    vga_ovr_d       = vga_ovr_q;
    cpu_addr_d      = cpu_addr_q;
    cpu_wdata_d     = cpu_wdata_q;
    cpu_be_d        = cpu_be_q;
    cpu_rd_d        = cpu_rd_q;
    cpu_inr_d       = cpu_inr_q;

    AVL_WAITREQUEST = 1'b1;
    AVL_READDATA    = '0;
    VGA_RDATA       = RESET ? '0 : vga_rdata_q;
    VGA_VALID       = 1'b0;
    RAM_ADDR        = '0;
    RAM_WE          = 1'b0;
    RAM_BE          = '0;
    RAM_WDATA       = '0;

    if (VGA_REQ) begin
      vga_pend_d      = 1'b1;
      vga_pend_addr_d = VGA_ADDR;
      if (vga_pend_q) begin
        vga_ovr_d = 1'b1;
      end
    end

    // Reset suppresses any completion visible in the same cycle; the access is dropped.
    if (!RESET) begin
      unique case (state_q)
        S_IDLE: begin
          if (vga_grant) begin
            state_d    = S_VGA_ISSUE;
            vga_pend_d = 1'b0;
            vga_addr_d = vga_sel_addr;
            vga_inr_d  = in_range(vga_sel_addr);
          end else if (cpu_grant) begin
            state_d     = S_CPU_ISSUE;
            cpu_addr_d  = AVL_ADDR;
            cpu_wdata_d = AVL_WRITEDATA;
            cpu_be_d    = AVL_BYTE_EN;
            cpu_rd_d    = AVL_READ;
            cpu_inr_d   = in_range(AVL_ADDR);
          end
        end
        S_VGA_ISSUE: begin
          RAM_ADDR = vga_addr_q;
          state_d  = S_VGA_DATA;
        end
        S_VGA_DATA: begin
          vga_rdata_d = vga_inr_q ? RAM_RDATA : '0;
          VGA_RDATA   = vga_rdata_d;
          VGA_VALID   = 1'b1;
          state_d     = S_IDLE;
        end
        S_CPU_ISSUE: begin
          RAM_ADDR = cpu_addr_q;
          if (cpu_rd_q) begin
            state_d = S_CPU_DATA;
          end else begin
            RAM_WE          = cpu_inr_q;
            RAM_BE          = cpu_inr_q ? cpu_be_q : 4'h0;
            RAM_WDATA       = cpu_wdata_q;
            AVL_WAITREQUEST = 1'b0;
            state_d         = S_IDLE;
          end
        end
        S_CPU_DATA: begin
          AVL_READDATA    = cpu_inr_q ? RAM_RDATA : '0;
          AVL_WAITREQUEST = 1'b0;
          state_d         = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a behavioural 1-cycle-latency VRAM model.
// Fairness sequence is compiled in only when VRAM_ARB_FAIRNESS_EN is defined.
module tb_vram_access_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [9:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        VGA_REQ;
  logic [9:0]  VGA_ADDR;
  logic [31:0] VGA_RDATA;
  logic        VGA_VALID, VGA_OVERRUN;
  logic [9:0]  RAM_ADDR;
  logic        RAM_WE;
  logic [3:0]  RAM_BE;
  logic [31:0] RAM_WDATA;
  logic [31:0] RAM_RDATA;

  vram_access_arbiter #(.DEPTH(600), .ADDR_W(10), .MAX_VGA_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_RDATA(VGA_RDATA),
    .VGA_VALID(VGA_VALID), .VGA_OVERRUN(VGA_OVERRUN),
    .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  // VRAM model covers the full address space so out-of-range words hold visible garbage.
  logic [31:0] mem [0:1023];
  logic        mem_init;
  int          we_count = 0;
  int          oob_writes = 0;
  logic [9:0]  last_we_addr = '0;

  function automatic logic [31:0] init_val(input int i);
    if (i >= 600) return 32'hBAD00000 | i;
    if (i < 16) return i * 32'h11111111;
    return 32'h0;
  endfunction

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (RAM_WE) begin
      for (int b = 0; b < 4; b++)
        if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
    end
    RAM_RDATA <= mem[RAM_ADDR];
    if (RAM_WE) begin
      we_count     <= we_count + 1;
      last_we_addr <= RAM_ADDR;
      if (RAM_ADDR >= 10'd600) oob_writes <= oob_writes + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One CPU transaction; lat is the cycle (request cycle = 0) where WAITREQUEST drops.
  task automatic cpu_xact(input logic rd, input logic both, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic [31:0] rdat);
    lat = -1;
    rdat = '0;
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = rd | both; AVL_WRITE = ~rd | both;
    AVL_ADDR = a; AVL_WRITEDATA = wd; AVL_BYTE_EN = be;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!AVL_WAITREQUEST) begin
        lat = k;
        rdat = AVL_READDATA;
        break;
      end
    end
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
  endtask

  int          cpu_k, vga_k, ovr_k, vga_cnt, vga_pre;
  logic [31:0] cpu_d, vga_d;

  // Runs n cycles with an optional CPU read from cycle 0 and VGA pulses per sched bit.
  task automatic window(input int n, input logic cpu_on, input logic [9:0] caddr,
                        input logic [31:0] sched, input logic [9:0] va, input logic [9:0] vb);
    int pulses;
    pulses = 0;
    cpu_k = -1; vga_k = -1; ovr_k = -1; vga_cnt = 0; vga_pre = 0;
    cpu_d = '0; vga_d = '0;
    @(posedge CLK); #1;
    AVL_CS = cpu_on; AVL_READ = cpu_on; AVL_WRITE = 1'b0; AVL_ADDR = caddr;
    for (int k = 0; k < n; k++) begin
      VGA_REQ = sched[k];
      VGA_ADDR = (pulses == 0) ? va : vb;
      if (sched[k]) pulses++;
      @(negedge CLK);
      if (VGA_VALID) begin
        vga_cnt++;
        if (cpu_k < 0) vga_pre++;
        if (vga_k < 0) begin vga_k = k; vga_d = VGA_RDATA; end
      end
      if (VGA_OVERRUN && ovr_k < 0) ovr_k = k;
      if (cpu_on && !AVL_WAITREQUEST && cpu_k < 0) begin cpu_k = k; cpu_d = AVL_READDATA; end
      @(posedge CLK); #1;
      if (cpu_k >= 0) begin AVL_CS = 1'b0; AVL_READ = 1'b0; end
    end
    VGA_REQ = 1'b0;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        both;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_we;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, we0, stuck;
    logic [31:0] rdat;

    vecs[0]  = '{1'b0, 1'b0, 10'd5,    32'hDEADBEEF, 4'hF, 1, 32'h0,        1};
    vecs[1]  = '{1'b1, 1'b0, 10'd5,    32'h0,        4'h0, 2, 32'hDEADBEEF, 0};
    vecs[2]  = '{1'b0, 1'b0, 10'd9,    32'h11223344, 4'hF, 1, 32'h0,        1};
    vecs[3]  = '{1'b0, 1'b0, 10'd9,    32'h00AB0000, 4'h4, 1, 32'h0,        1};
    vecs[4]  = '{1'b1, 1'b0, 10'd9,    32'h0,        4'h0, 2, 32'h11AB3344, 0};
    vecs[5]  = '{1'b0, 1'b0, 10'd600,  32'h12345678, 4'hF, 1, 32'h0,        0};
    vecs[6]  = '{1'b1, 1'b0, 10'd600,  32'h0,        4'h0, 2, 32'h0,        0};
    vecs[7]  = '{1'b1, 1'b0, 10'd1023, 32'h0,        4'h0, 2, 32'h0,        0};
    vecs[8]  = '{1'b0, 1'b0, 10'd599,  32'hA5A5A5A5, 4'h3, 1, 32'h0,        1};
    vecs[9]  = '{1'b0, 1'b0, 10'd7,    32'hCAFEF00D, 4'hF, 1, 32'h0,        1};
    vecs[10] = '{1'b1, 1'b0, 10'd599,  32'h0,        4'h0, 2, 32'h0000A5A5, 0};
    vecs[11] = '{1'b1, 1'b1, 10'd7,    32'hFFFFFFFF, 4'hF, 2, 32'hCAFEF00D, 0};
    vecs[12] = '{1'b1, 1'b0, 10'd7,    32'h0,        4'h0, 2, 32'hCAFEF00D, 0};

    RESET = 1'b1; mem_init = 1'b1;
    AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0; AVL_BYTE_EN = '0;
    AVL_ADDR = '0; AVL_WRITEDATA = '0; VGA_REQ = 1'b0; VGA_ADDR = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_waitreq", {31'b0, AVL_WAITREQUEST}, 32'd1);
    check("rst_readdata", AVL_READDATA, 32'h0);
    check("rst_vga_rdata", VGA_RDATA, 32'h0);
    check("rst_vga_valid", {31'b0, VGA_VALID}, 32'd0);
    check("rst_overrun", {31'b0, VGA_OVERRUN}, 32'd0);
    check("rst_ram_we", {31'b0, RAM_WE}, 32'd0);
    check("rst_ram_be", {28'b0, RAM_BE}, 32'd0);
    check("rst_ram_addr", {22'b0, RAM_ADDR}, 32'd0);
    check("rst_ram_wdata", RAM_WDATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0; mem_init = 1'b0;
    @(negedge CLK);
    check("idle_waitreq", {31'b0, AVL_WAITREQUEST}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      we0 = we_count;
      cpu_xact(vecs[i].rd, vecs[i].both, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rdat);
      $display("vec %0d rd=%0b addr=%0d lat=%0d rdata=%08h", i, vecs[i].rd, vecs[i].addr, lat, rdat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].rd) check($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rdata);
      check($sformatf("v%0d_we_cycles", i), we_count - we0, vecs[i].exp_we);
      if (vecs[i].exp_we != 0) check($sformatf("v%0d_we_addr", i), {22'b0, last_we_addr}, {22'b0, vecs[i].addr});
    end

    // Simultaneous VGA fetch and CPU read: VGA first, CPU after the dead cycle.
    window(10, 1'b1, 10'd7, 32'h1, 10'd5, 10'd5);
    $display("sim vga_k=%0d vga=%08h cpu_k=%0d cpu=%08h", vga_k, vga_d, cpu_k, cpu_d);
    check("sim_vga_cycle", vga_k, 2);
    check("sim_vga_data", vga_d, 32'hDEADBEEF);
    check("sim_cpu_cycle", cpu_k, 5);
    check("sim_cpu_data", cpu_d, 32'hCAFEF00D);
    check("sim_vga_count", vga_cnt, 1);

    // Out-of-range VGA fetch returns zero.
    window(6, 1'b0, 10'd0, 32'h1, 10'd700, 10'd700);
    $display("vga_oob vga_k=%0d vga=%08h", vga_k, vga_d);
    check("vga_oob_cycle", vga_k, 2);
    check("vga_oob_data", vga_d, 32'h0);

    // Two fetch pulses while the CPU owns the RAM: overrun, one fetch of the newer address.
    window(10, 1'b1, 10'd9, 32'h6, 10'd1, 10'd2);
    $display("ovr cpu_k=%0d vga_k=%0d vga=%08h ovr_k=%0d cnt=%0d", cpu_k, vga_k, vga_d, ovr_k, vga_cnt);
    check("ovr_cpu_cycle", cpu_k, 2);
    check("ovr_cpu_data", cpu_d, 32'h11AB3344);
    check("ovr_flag_cycle", ovr_k, 3);
    check("ovr_vga_count", vga_cnt, 1);
    check("ovr_vga_cycle", vga_k, 5);
    check("ovr_vga_data", vga_d, 32'h22222222);

    // Reset landing in CPU_DATA aborts the read.
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 10'd5;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rstmid_waitreq", {31'b0, AVL_WAITREQUEST}, 32'd1);
    check("rstmid_readdata", AVL_READDATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0; AVL_CS = 1'b0; AVL_READ = 1'b0;
    @(negedge CLK);
    check("rstpost_waitreq", {31'b0, AVL_WAITREQUEST}, 32'd1);
    check("rstpost_overrun", {31'b0, VGA_OVERRUN}, 32'd0);
    $display("reset mid-read: waitreq=%0b overrun=%0b", AVL_WAITREQUEST, VGA_OVERRUN);
    cpu_xact(1'b1, 1'b0, 10'd600, 32'h0, 4'h0, lat, rdat);
    $display("post-reset read 600 lat=%0d rdata=%08h", lat, rdat);
    check("rd600_latency", lat, 2);
    check("rd600_data", rdat, 32'h0);

    // Chip select low: requests are ignored.
    stuck = 0;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b1; AVL_ADDR = 10'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (!AVL_WAITREQUEST || RAM_ADDR != 10'd0) stuck++;
    end
    @(posedge CLK); #1;
    AVL_READ = 1'b0;
    $display("cs low: active cycles=%0d", stuck);
    check("cs_low_ignored", stuck, 0);

`ifdef VRAM_ARB_FAIRNESS_EN
    // VGA every 3 cycles would starve the CPU; the burst limit lets it in after 4 grants.
    window(24, 1'b1, 10'd5, 32'h1249, 10'd3, 10'd4);
    $display("fair cpu_k=%0d vga_before=%0d cpu=%08h", cpu_k, vga_pre, cpu_d);
    check("fair_cpu_cycle", cpu_k, 14);
    check("fair_vga_grants", vga_pre, 4);
    check("fair_cpu_data", cpu_d, 32'hDEADBEEF);
`endif

    repeat (3) @(posedge CLK);
    check("no_oob_writes", oob_writes, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
